// File: rtl/branch_predictor_bht_if.sv
// Lookup, resolve/redirect and statistics signals of the branch history table.
// master = fetch/execute pipeline side, slave = predictor.
interface branch_predictor_bht_if #(
  parameter int IDX_BITS  = 4,
  parameter int STAT_BITS = 32
);
  logic                 clr_i;
  logic [31:0]          lkp_pc_i;
  logic                 predict_o;
  logic [IDX_BITS-1:0]  pred_idx_o;
  logic                 update_i;
  logic [IDX_BITS-1:0]  upd_idx_i;
  logic                 upd_pred_i;
  logic                 upd_taken_i;
  logic [31:0]          Ttarget_i;
  logic [31:0]          NTtarget_i;
  logic                 mispredict_o;
  logic [31:0]          RealTarget_o;
  logic [STAT_BITS-1:0] br_cnt_o;
  logic [STAT_BITS-1:0] miss_cnt_o;

  modport master (
    output clr_i, lkp_pc_i, update_i, upd_idx_i, upd_pred_i, upd_taken_i,
           Ttarget_i, NTtarget_i,
    input  predict_o, pred_idx_o, mispredict_o, RealTarget_o, br_cnt_o, miss_cnt_o
  );

  modport slave (
    input  clr_i, lkp_pc_i, update_i, upd_idx_i, upd_pred_i, upd_taken_i,
           Ttarget_i, NTtarget_i,
    output predict_o, pred_idx_o, mispredict_o, RealTarget_o, br_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters, bimodal (GHR_BITS=0) or gshare.
// Combinational lookup, trained by resolved branches, raises flush + corrected PC
// on a misprediction and keeps saturating branch/miss statistics.
module branch_predictor_bht #(
  parameter int IDX_BITS  = 4,
  parameter int GHR_BITS  = 0,
  parameter int CNT_BITS  = 2,
  parameter int INIT_CNT  = 3,
  parameter int STAT_BITS = 32
) (
  input logic clk_i,
  input logic rst_i,
  branch_predictor_bht_if.slave bus
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(INIT_CNT);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [CNT_BITS-1:0]  tbl [ENTRIES];
  logic [IDX_BITS-1:0]  pc_idx;
  logic [IDX_BITS-1:0]  lkp_idx;
  logic                 mispredict;
  logic [STAT_BITS-1:0] br_cnt;
  logic [STAT_BITS-1:0] miss_cnt;
  logic                 unused_pc_bits;

  assign pc_idx         = bus.lkp_pc_i[IDX_BITS+1:2];
  assign unused_pc_bits = ^{bus.lkp_pc_i[31:IDX_BITS+2], bus.lkp_pc_i[1:0]};

  generate
    if (GHR_BITS == 0) begin : g_bimodal
      assign lkp_idx = pc_idx;
    end else begin : g_gshare
      logic [GHR_BITS-1:0] ghr;
      logic [GHR_BITS-1:0] ghr_next;

      if (GHR_BITS == 1) begin : g_ghr1
        assign ghr_next = bus.upd_taken_i;
      end else begin : g_ghrn
        assign ghr_next = {ghr[GHR_BITS-2:0], bus.upd_taken_i};
      end

      // Committed global history: shifts in each resolved outcome
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)           ghr <= '0;
        else if (bus.clr_i)   ghr <= '0;
        else if (bus.update_i) ghr <= ghr_next;
      end

      assign lkp_idx = pc_idx ^ IDX_BITS'(ghr);
    end
  endgenerate

  // Pattern table training: saturating up on taken, down on not taken
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= CNT_INIT;
    end else if (bus.clr_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= CNT_INIT;
    end else if (bus.update_i) begin
      if (bus.upd_taken_i) begin
        if (tbl[bus.upd_idx_i] != CNT_MAX) tbl[bus.upd_idx_i] <= tbl[bus.upd_idx_i] + 1'b1;
      end else begin
        if (tbl[bus.upd_idx_i] != '0) tbl[bus.upd_idx_i] <= tbl[bus.upd_idx_i] - 1'b1;
      end
    end
  end

  assign mispredict = bus.update_i & (bus.upd_pred_i != bus.upd_taken_i);

  // Statistics: saturate at all-ones instead of wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (bus.clr_i) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (bus.update_i) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  assign bus.pred_idx_o   = lkp_idx;
  assign bus.predict_o    = tbl[lkp_idx][CNT_BITS-1];
  assign bus.mispredict_o = mispredict;
  assign bus.RealTarget_o = bus.upd_taken_i ? bus.Ttarget_i : bus.NTtarget_i;
  assign bus.br_cnt_o     = br_cnt;
  assign bus.miss_cnt_o   = miss_cnt;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench: bimodal instance (table vectors) and gshare instance with
// 2-bit statistics (history indexing and stat saturation).
module tb_branch_predictor_bht;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_predictor_bht_if #(.IDX_BITS(4), .STAT_BITS(32)) bus_b ();
  branch_predictor_bht_if #(.IDX_BITS(4), .STAT_BITS(2))  bus_g ();

  branch_predictor_bht #(
    .IDX_BITS(4), .GHR_BITS(0), .CNT_BITS(2), .INIT_CNT(3), .STAT_BITS(32)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave)
  );

  branch_predictor_bht #(
    .IDX_BITS(4), .GHR_BITS(4), .CNT_BITS(2), .INIT_CNT(3), .STAT_BITS(2)
  ) dut_g (
    .clk_i(clk), .rst_i(rst), .bus(bus_g.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        upd;
    logic [3:0]  idx;
    logic        pred;
    logic        taken;
    logic [31:0] lkp;
    logic        exp_before;
    logic        exp_mis;
    logic [31:0] exp_real;
    logic        exp_after;
    logic [31:0] exp_br;
    logic [31:0] exp_miss;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int n, input vec_t v);
    @(negedge clk);
    bus_b.update_i    = v.upd;
    bus_b.upd_idx_i   = v.idx;
    bus_b.upd_pred_i  = v.pred;
    bus_b.upd_taken_i = v.taken;
    bus_b.lkp_pc_i    = v.lkp;
    #1;
    check($sformatf("v%0d pred_idx", n), 32'(bus_b.pred_idx_o), 32'(v.idx));
    check($sformatf("v%0d predict_before", n), 32'(bus_b.predict_o), 32'(v.exp_before));
    check($sformatf("v%0d mispredict", n), 32'(bus_b.mispredict_o), 32'(v.exp_mis));
    check($sformatf("v%0d real_target", n), bus_b.RealTarget_o, v.exp_real);
    @(posedge clk);
    #1;
    bus_b.update_i = 1'b0;
    check($sformatf("v%0d predict_after", n), 32'(bus_b.predict_o), 32'(v.exp_after));
    check($sformatf("v%0d br_cnt", n), bus_b.br_cnt_o, v.exp_br);
    check($sformatf("v%0d miss_cnt", n), bus_b.miss_cnt_o, v.exp_miss);
  endtask

  // gshare update with upd_pred=0 and lookup PC 0x08 (pc_idx 4'b0010)
  task automatic g_upd(input string nm, input logic taken, input logic [3:0] idx_before,
                       input logic [3:0] idx_after, input logic [1:0] br, input logic [1:0] miss);
    @(negedge clk);
    bus_g.update_i    = 1'b1;
    bus_g.upd_idx_i   = 4'd0;
    bus_g.upd_pred_i  = 1'b0;
    bus_g.upd_taken_i = taken;
    bus_g.lkp_pc_i    = 32'h08;
    #1;
    check({nm, " idx_before"}, 32'(bus_g.pred_idx_o), 32'(idx_before));
    @(posedge clk);
    #1;
    bus_g.update_i = 1'b0;
    check({nm, " idx_after"}, 32'(bus_g.pred_idx_o), 32'(idx_after));
    check({nm, " br_cnt"}, 32'(bus_g.br_cnt_o), 32'(br));
    check({nm, " miss_cnt"}, 32'(bus_g.miss_cnt_o), 32'(miss));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //            upd idx pred tkn lkp     bef mis real      aft br  miss
    vecs[0]  = '{1'b1, 4'd5, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 32'h104, 1'b1, 1,  0};
    vecs[1]  = '{1'b1, 4'd5, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 32'h104, 1'b0, 2,  0};
    vecs[2]  = '{1'b1, 4'd5, 1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 32'h104, 1'b0, 3,  0};
    vecs[3]  = '{1'b1, 4'd5, 1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 32'h104, 1'b0, 4,  0};
    vecs[4]  = '{1'b1, 4'd5, 1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 32'h104, 1'b0, 5,  0};
    vecs[5]  = '{1'b1, 4'd5, 1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h300, 1'b0, 6,  0};
    vecs[6]  = '{1'b1, 4'd5, 1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h300, 1'b1, 7,  0};
    vecs[7]  = '{1'b1, 4'd5, 1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 32'h300, 1'b1, 8,  0};
    vecs[8]  = '{1'b1, 4'd5, 1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 32'h300, 1'b1, 9,  0};
    vecs[9]  = '{1'b1, 4'd9, 1'b1, 1'b0, 32'h24, 1'b1, 1'b1, 32'h104, 1'b1, 10, 1};
    vecs[10] = '{1'b1, 4'd9, 1'b0, 1'b1, 32'h24, 1'b1, 1'b1, 32'h300, 1'b1, 11, 2};
    vecs[11] = '{1'b0, 4'd9, 1'b1, 1'b0, 32'h24, 1'b1, 1'b0, 32'h104, 1'b1, 11, 2};
    vecs[12] = '{1'b1, 4'd3, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b0, 32'h104, 1'b1, 12, 2};
    vecs[13] = '{1'b1, 4'd3, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b0, 32'h104, 1'b0, 13, 2};

    rst = 1'b0;
    bus_b.clr_i = 1'b0; bus_b.lkp_pc_i = 32'h40; bus_b.update_i = 1'b0;
    bus_b.upd_idx_i = '0; bus_b.upd_pred_i = 1'b0; bus_b.upd_taken_i = 1'b0;
    bus_b.Ttarget_i = 32'h300; bus_b.NTtarget_i = 32'h104;
    bus_g.clr_i = 1'b0; bus_g.lkp_pc_i = 32'h08; bus_g.update_i = 1'b0;
    bus_g.upd_idx_i = '0; bus_g.upd_pred_i = 1'b0; bus_g.upd_taken_i = 1'b0;
    bus_g.Ttarget_i = 32'h300; bus_g.NTtarget_i = 32'h104;

    repeat (2) @(posedge clk);
    #1;
    check("in_reset predict", 32'(bus_b.predict_o), 32'd1);

    // T1: reset release
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1 predict", 32'(bus_b.predict_o), 32'd1);
    check("t1 pred_idx", 32'(bus_b.pred_idx_o), 32'd0);
    check("t1 br_cnt", bus_b.br_cnt_o, 32'd0);
    check("t1 miss_cnt", bus_b.miss_cnt_o, 32'd0);
    check("t1 g pred_idx", 32'(bus_g.pred_idx_o), 32'd2);

    // T2..T4: saturation, mispredict, same-cycle conflict
    for (int i = 0; i < 14; i++) apply_vec(i, vecs[i]);

    // T6 bimodal: clear wins over a simultaneous update (idx 3 counter is 1 here)
    @(negedge clk);
    bus_b.clr_i = 1'b1; bus_b.update_i = 1'b1; bus_b.upd_idx_i = 4'd3;
    bus_b.upd_pred_i = 1'b1; bus_b.upd_taken_i = 1'b0; bus_b.lkp_pc_i = 32'h0C;
    #1;
    check("t6 mispredict_comb", 32'(bus_b.mispredict_o), 32'd1);
    @(posedge clk);
    #1;
    bus_b.clr_i = 1'b0; bus_b.update_i = 1'b0;
    check("t6 predict", 32'(bus_b.predict_o), 32'd1);
    check("t6 br_cnt", bus_b.br_cnt_o, 32'd0);
    check("t6 miss_cnt", bus_b.miss_cnt_o, 32'd0);
    // one not-taken after clear: 3 -> 2 still predicts taken
    apply_vec(14, '{1'b1, 4'd3, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b0, 32'h104, 1'b1, 1, 0});

    // T5 gshare history and 2-bit stat saturation
    g_upd("g1", 1'b1, 4'b0010, 4'b0011, 2'd1, 2'd1);
    g_upd("g2", 1'b1, 4'b0011, 4'b0001, 2'd2, 2'd2);
    g_upd("g3", 1'b0, 4'b0001, 4'b0100, 2'd3, 2'd2);
    g_upd("g4", 1'b1, 4'b0100, 4'b1111, 2'd3, 2'd3);
    g_upd("g5", 1'b1, 4'b1111, 4'b1001, 2'd3, 2'd3);

    // Asynchronous reset mid-cycle, with an update pending on the bimodal side
    @(negedge clk);
    bus_b.update_i = 1'b1; bus_b.upd_idx_i = 4'd3; bus_b.upd_pred_i = 1'b1;
    bus_b.upd_taken_i = 1'b0; bus_b.lkp_pc_i = 32'h0C;
    #2;
    rst = 1'b0;
    #1;
    check("arst g br_cnt", 32'(bus_g.br_cnt_o), 32'd0);
    check("arst g miss_cnt", 32'(bus_g.miss_cnt_o), 32'd0);
    check("arst g pred_idx", 32'(bus_g.pred_idx_o), 32'd2);
    check("arst b br_cnt", bus_b.br_cnt_o, 32'd0);
    check("arst b mispredict", 32'(bus_b.mispredict_o), 32'd1);
    @(posedge clk);
    #1;
    check("arst b predict_hold", 32'(bus_b.predict_o), 32'd1);
    check("arst b br_hold", bus_b.br_cnt_o, 32'd0);
    @(negedge clk);
    bus_b.update_i = 1'b0;
    rst = 1'b1;

    // T6 gshare: clear drops a simultaneous update and zeroes the history
    g_upd("g6", 1'b1, 4'b0010, 4'b0011, 2'd1, 2'd1);
    @(negedge clk);
    bus_g.clr_i = 1'b1; bus_g.update_i = 1'b1; bus_g.upd_taken_i = 1'b1;
    @(posedge clk);
    #1;
    bus_g.clr_i = 1'b0; bus_g.update_i = 1'b0;
    check("t6 g pred_idx", 32'(bus_g.pred_idx_o), 32'd2);
    check("t6 g br_cnt", 32'(bus_g.br_cnt_o), 32'd0);
    check("t6 g miss_cnt", 32'(bus_g.miss_cnt_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
